// File: rtl/store_commit_buffer.sv
// Store commit buffer: queues committed stores from the ROB, drains them in
// order to the dataCache write port, and forwards buffered data to loads.
module store_commit_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  commitEnable,
  input  logic [ADDR_WIDTH-1:0] commitAddr,
  input  logic [DATA_WIDTH-1:0] commitData,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  cacheWriteEnable,
  output logic [ADDR_WIDTH-1:0] cacheWriteAddr,
  output logic [DATA_WIDTH-1:0] cacheWriteData,
  input  logic                  cacheWriteDone,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  output logic                  fwdHit,
  output logic [DATA_WIDTH-1:0] fwdData
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_count_next;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_pop  = (r_state == REQ) && cacheWriteDone;
  // A pop on the same edge frees the slot, so a push at full is still taken
  assign w_push = commitEnable && (!w_full || w_pop);

  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Empty buffer with a same-edge push: the new head is the incoming store
  assign w_head_addr = (r_count == '0) ? commitAddr : r_mem_addr[r_head];
  assign w_head_data = (r_count == '0) ? commitData : r_mem_data[r_head];

  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) &&
          (r_mem_addr[r_head + PW'(i)][ADDR_WIDTH-1:2] ==
           loadAddr[ADDR_WIDTH-1:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_mem_data[r_head + PW'(i)];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      if (w_push) begin
        r_mem_addr[r_tail] <= commitAddr;
        r_mem_data[r_tail] <= commitData;
        r_tail             <= r_tail + PW'(1);
      end
      if (w_pop)
        r_head <= r_head + PW'(1);
      r_count <= w_count_next;
      if (commitEnable && w_full && !w_pop)
        r_overflow <= 1'b1;

      unique case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_state <= REQ;
            r_we    <= 1'b1;
            r_waddr <= r_mem_addr[r_head];
            r_wdata <= r_mem_data[r_head];
          end
        end
        REQ: begin
          if (cacheWriteDone) begin
            r_state <= GAP;
            r_we    <= 1'b0;
          end
        end
        GAP: begin
          if (w_count_next != '0) begin
            r_state <= REQ;
            r_we    <= 1'b1;
            r_waddr <= w_head_addr;
            r_wdata <= w_head_data;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign full             = w_full;
  assign empty            = (r_count == '0);
  assign count            = r_count;
  assign overflow         = r_overflow;
  assign cacheWriteEnable = r_we;
  assign cacheWriteAddr   = r_waddr;
  assign cacheWriteData   = r_wdata;
  assign fwdHit           = w_fwd_hit;
  assign fwdData          = w_fwd_data;

endmodule
